// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg: control encodings and flag indices shared by controller/datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arm_pkg;

    typedef enum logic [1:0] {
        SRCA_REG  = 2'b00,
        SRCA_PC   = 2'b01,
        SRCA_RSV2 = 2'b10,
        SRCA_RSV3 = 2'b11
    } alusrca_e;

    typedef enum logic [1:0] {
        SRCB_WD   = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'b00,
        RES_DATA    = 2'b01,
        RES_ALU     = 2'b10,
        RES_ALUOUT2 = 2'b11
    } resultsrc_e;

    typedef enum logic [1:0] {
        IMM_8    = 2'b00,
        IMM_12   = 2'b01,
        IMM_BR   = 2'b10,
        IMM_ZERO = 2'b11
    } immsrc_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } aluctl_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/datapath_if.sv
// ---------------------------------------------------------------------------
// datapath_if: controller/memory <-> datapath signal bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface datapath_if;
    import arm_pkg::*;

    logic [31:0] ReadData;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    alusrca_e    ALUSrcA;
    alusrcb_e    ALUSrcB;
    resultsrc_e  ResultSrc;
    immsrc_e     ImmSrc;
    aluctl_e     ALUControl;

    modport master (
        output ReadData, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
        input  Adr, WriteData, Instr, ALUFlags
    );

    modport slave (
        input  ReadData, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
        output Adr, WriteData, Instr, ALUFlags
    );

endinterface

`default_nettype wire

// File: rtl/datapath_regfile.sv
// ---------------------------------------------------------------------------
// regfile: r0-r14, two combinational reads, one synchronous write, r15 bypass
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [3:0]  ra1_i,
    input  wire logic [3:0]  ra2_i,
    input  wire logic [3:0]  wa_i,
    input  wire logic        we_i,
    input  wire logic [31:0] wd_i,
    input  wire logic [31:0] r15_i,
    output logic      [31:0] rd1_o,
    output logic      [31:0] rd2_o
);

    logic [31:0] regs_q [0:14];

    // r15 is not storage: writes to it are dropped, the PC owns that value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 4'hF)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 4'hF) ? r15_i : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 4'hF) ? r15_i : regs_q[ra2_i];

endmodule

`default_nettype wire

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath: multicycle ARM datapath (PC, regfile, IR/Data/A/B/ALUOut, ALU)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module datapath
    import arm_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    datapath_if.slave  bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] data_q;
    logic [31:0] a_q;
    logic [31:0] wd_q;
    logic [31:0] aluout_q;

    logic [3:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic [31:0] ext_imm, src_a, src_b, b_op, alu_result, result;
    logic [32:0] sum;
    logic        is_sub, is_arith;

    assign ra1 = bus.RegSrc[0] ? 4'hF : ir_q[19:16];
    assign ra2 = bus.RegSrc[1] ? ir_q[15:12] : ir_q[3:0];

    regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1_i (ra1),
        .ra2_i (ra2),
        .wa_i  (ir_q[15:12]),
        .we_i  (bus.RegWrite),
        .wd_i  (result),
        .r15_i (result),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    always_comb begin
        ext_imm = '0;
        case (bus.ImmSrc)
            IMM_8:    ext_imm = {24'd0, ir_q[7:0]};
            IMM_12:   ext_imm = {20'd0, ir_q[11:0]};
            IMM_BR:   ext_imm = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
            default:  ext_imm = '0;
        endcase
    end

    assign src_a = (bus.ALUSrcA == SRCA_PC) ? pc_q : a_q;

    always_comb begin
        src_b = '0;
        case (bus.ALUSrcB)
            SRCB_WD:   src_b = wd_q;
            SRCB_IMM:  src_b = ext_imm;
            SRCB_FOUR: src_b = 32'd4;
            default:   src_b = '0;
        endcase
    end

    // Subtract reuses the adder as A + ~B + 1, so carry-out is NOT borrow
    assign is_sub   = (bus.ALUControl == ALU_SUB);
    assign is_arith = (bus.ALUControl == ALU_ADD) || is_sub;
    assign b_op     = is_sub ? ~src_b : src_b;
    assign sum      = {1'b0, src_a} + {1'b0, b_op} + {32'd0, is_sub};

    always_comb begin
        alu_result = sum[31:0];
        case (bus.ALUControl)
            ALU_AND: alu_result = src_a & src_b;
            ALU_ORR: alu_result = src_a | src_b;
            default: alu_result = sum[31:0];
        endcase
    end

    always_comb begin
        bus.ALUFlags         = '0;
        bus.ALUFlags[FLAG_N] = alu_result[31];
        bus.ALUFlags[FLAG_Z] = (alu_result == 32'd0);
        bus.ALUFlags[FLAG_C] = is_arith & sum[32];
        bus.ALUFlags[FLAG_V] = is_arith & (src_a[31] == b_op[31])
                                        & (sum[31] != src_a[31]);
    end

    always_comb begin
        result = aluout_q;
        case (bus.ResultSrc)
            RES_DATA: result = data_q;
            RES_ALU:  result = alu_result;
            default:  result = aluout_q;
        endcase
    end

    assign pc_d = bus.PCWrite ? result : pc_q;
    assign ir_d = bus.IRWrite ? bus.ReadData : ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            data_q   <= '0;
            a_q      <= '0;
            wd_q     <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            data_q   <= bus.ReadData;
            a_q      <= rd1;
            wd_q     <= rd2;
            aluout_q <= alu_result;
        end
    end

    assign bus.Adr       = bus.AdrSrc ? result : pc_q;
    assign bus.Instr     = ir_q;
    assign bus.WriteData = wd_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath: directed vectors for the multicycle datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_datapath;
    import arm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    datapath_if bus ();

    datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.ReadData   = '0;
        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.RegSrc     = 2'b00;
        bus.ALUSrcA    = SRCA_REG;
        bus.ALUSrcB    = SRCB_WD;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ImmSrc     = IMM_8;
        bus.ALUControl = ALU_ADD;
    endtask

    task automatic randomize_ctl();
        bus.ReadData   = $urandom;
        bus.PCWrite    = 1'($urandom_range(0, 1));
        bus.RegWrite   = 1'($urandom_range(0, 1));
        bus.IRWrite    = 1'($urandom_range(0, 1));
        bus.AdrSrc     = 1'($urandom_range(0, 1));
        bus.RegSrc     = 2'($urandom_range(0, 3));
        bus.ALUSrcA    = alusrca_e'($urandom_range(0, 3));
        bus.ALUSrcB    = alusrcb_e'($urandom_range(0, 3));
        bus.ResultSrc  = resultsrc_e'($urandom_range(0, 3));
        bus.ImmSrc     = immsrc_e'($urandom_range(0, 3));
        bus.ALUControl = aluctl_e'($urandom_range(0, 3));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] w);
        idle();
        bus.ReadData = w;
        bus.IRWrite  = 1'b1;
        tick();
        idle();
    endtask

    // A <- r15 while Result is the Data register, i.e. A <- v
    task automatic set_a(input logic [31:0] v);
        idle();
        bus.ReadData = v;
        tick();
        bus.RegSrc    = 2'b01;
        bus.ResultSrc = RES_DATA;
        tick();
        idle();
    endtask

    task automatic write_rd(input logic [31:0] v);
        idle();
        bus.ReadData = v;
        tick();
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        tick();
        idle();
    endtask

    task automatic fetch(input logic [31:0] w);
        idle();
        bus.ReadData  = w;
        bus.IRWrite   = 1'b1;
        bus.PCWrite   = 1'b1;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        tick();
        idle();
    endtask

    task automatic decode();
        idle();
        bus.RegSrc    = 2'b01;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        tick();
        idle();
    endtask

    task automatic peek_a(input string tag, input logic [31:0] exp);
        idle();
        bus.ALUSrcB   = SRCB_ZERO;
        bus.ResultSrc = RES_ALU;
        bus.AdrSrc    = 1'b1;
        #1;
        check_eq(tag, bus.Adr, exp);
    endtask

    task automatic peek_pc(input string tag, input logic [31:0] exp);
        idle();
        #1;
        check_eq(tag, bus.Adr, exp);
    endtask

    task automatic imm_flags(input logic [31:0] ir, input logic [31:0] a,
                             input aluctl_e op, input string tag, input logic [3:0] exp);
        load_ir(ir);
        set_a(a);
        bus.ALUSrcB    = SRCB_IMM;
        bus.ImmSrc     = IMM_8;
        bus.ALUControl = op;
        #1;
        check_eq(tag, {28'd0, bus.ALUFlags}, {28'd0, exp});
    endtask

    task automatic br_ext(input logic [31:0] ir, input string tag, input logic [31:0] exp);
        load_ir(ir);
        set_a(32'd0);
        bus.ALUSrcB   = SRCB_IMM;
        bus.ImmSrc    = IMM_BR;
        bus.ResultSrc = RES_ALU;
        bus.AdrSrc    = 1'b1;
        #1;
        check_eq(tag, bus.Adr, exp);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_ctl();
            tick();
        end
        reset = 1'b0;
        idle();
        #1;
        check_eq("rst_adr", bus.Adr, 32'd0);
        check_eq("rst_instr", bus.Instr, 32'd0);
        check_eq("rst_wdata", bus.WriteData, 32'd0);

        fetch(32'hE590_2060);
        check_eq("fetch_instr", bus.Instr, 32'hE590_2060);
        peek_pc("fetch_pc", 32'd4);
        decode();
        peek_a("decode_r15", 32'd8);

        // LDR r2, [r0, #0x60] with r0 = 0x100
        load_ir(32'h0000_0000);
        write_rd(32'h0000_0100);
        load_ir(32'hE590_2060);
        tick();
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = IMM_12;
        tick();
        idle();
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = RES_ALUOUT;
        bus.ReadData  = 32'hDEAD_BEEF;
        #1;
        check_eq("ldr_adr", bus.Adr, 32'h0000_0160);
        tick();
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        tick();
        idle();
        bus.RegSrc = 2'b10;
        tick();
        check_eq("ldr_r2", bus.WriteData, 32'hDEAD_BEEF);

        // STR r2, [r0, #0x64] with r2 = 0x1234
        write_rd(32'h0000_1234);
        load_ir(32'hE580_2064);
        bus.RegSrc = 2'b10;
        tick();
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = IMM_12;
        tick();
        idle();
        bus.RegSrc    = 2'b10;
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = RES_ALUOUT;
        #1;
        check_eq("str_adr", bus.Adr, 32'h0000_0164);
        check_eq("str_wdata", bus.WriteData, 32'h0000_1234);

        imm_flags(32'h0000_F005, 32'h0000_0005, ALU_SUB, "flags_sub", 4'b0110);
        imm_flags(32'h0000_F001, 32'h7FFF_FFFF, ALU_ADD, "flags_add_ovf", 4'b1001);
        imm_flags(32'h0000_F00F, 32'h0000_00F0, ALU_AND, "flags_and", 4'b0100);

        br_ext(32'h0A00_000C, "ext_br_pos", 32'h0000_0030);
        br_ext(32'h0AFF_FFFE, "ext_br_neg", 32'hFFFF_FFF8);

        // Branch fetched at PC=4: target = 4 + 8 + 0x30
        fetch(32'h0A00_000C);
        decode();
        bus.ALUSrcB   = SRCB_IMM;
        bus.ImmSrc    = IMM_BR;
        bus.ResultSrc = RES_ALU;
        bus.PCWrite   = 1'b1;
        tick();
        peek_pc("branch_pc", 32'h0000_003C);

        idle();
        bus.ReadData = 32'hFFFF_FFFC;
        tick();
        bus.ResultSrc = RES_DATA;
        bus.PCWrite   = 1'b1;
        tick();
        peek_pc("pc_top", 32'hFFFF_FFFC);
        fetch(32'h0000_0000);
        peek_pc("pc_wrap", 32'd0);

        // Same-cycle write and read of r2: A sees the old value
        load_ir(32'h0002_2000);
        bus.ReadData = 32'h0000_5555;
        tick();
        idle();
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        tick();
        peek_a("wr_rd_old", 32'h0000_1234);
        tick();
        peek_a("wr_rd_new", 32'h0000_5555);

        // Reset in the middle of a writeback
        load_ir(32'h0000_0000);
        bus.ReadData = 32'h0000_AAAA;
        tick();
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        bus.PCWrite   = 1'b1;
        reset         = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        check_eq("abort_pc", bus.Adr, 32'd0);
        check_eq("abort_instr", bus.Instr, 32'd0);
        check_eq("abort_wdata", bus.WriteData, 32'd0);
        tick();
        peek_a("abort_r0", 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/datapath.md
# datapath

Multicycle ARM datapath that sits directly downstream of the multicycle `controller`. It consumes the controller's per-cycle control strobes and returns to it the latched instruction and the ALU flags. It owns the architectural state (PC, r0–r14) and the non-architectural multicycle registers (IR, Data, A, WriteData, ALUOut). It drives the single unified instruction/data memory address.

## Interface
- No parameters; width fixed at 32 bits.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ReadData  in  32  memory read data, valid in the same cycle as Adr.
- Adr  out  32  memory address.
- WriteData  out  32  store data; this is the B register.
- Instr  out  32  IR contents; the controller uses Instr[31:12].
- ALUFlags  out  4  {N,Z,C,V} from the current ALU result.
- PCWrite, RegWrite, IRWrite, AdrSrc  in  1 each  controller strobes.
- RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl  in  2 each  controller selects.

## Operation
- **Read addresses.** RA1 = RegSrc[0] ? 15 : Instr[19:16]. RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
- **Register file.** 15 registers, r0–r14.
  - Write: Result to Instr[15:12] when RegWrite is high.
  - Reading r15 returns the current Result.
  - Reads are combinational.
- **Extend (ImmSrc).**
  - 00: zero-extend Instr[7:0].
  - 01: zero-extend Instr[11:0].
  - 10: sign-extend Instr[23:0], then shift left by 2.
  - 11: 0.
- **SrcA (ALUSrcA).** 01 = PC; any other value = A.
- **SrcB (ALUSrcB).** 00 = WriteData; 01 = ExtImm; 10 = 32'd4; 11 = 0.
- **ALUControl.** 00 add; 01 sub (SrcA + ~SrcB + 1); 10 and; 11 orr.
- **Flags.**
  - N = result[31]; Z = (result == 0).
  - C = carry-out for add/sub, with sub carry = NOT borrow.
  - V = signed overflow for add/sub.
  - C and V are 0 for and/orr.
- **Result (ResultSrc).** 00 = ALUOut; 01 = Data; 10 = ALUResult; 11 = ALUOut.
- **Address.** Adr = AdrSrc ? Result : PC.
- **Register updates at each rising edge:**
  - PC ← Result if PCWrite.
  - IR ← ReadData if IRWrite.
  - Data ← ReadData, every cycle.
  - A ← RD1, every cycle.
  - WriteData ← RD2, every cycle.
  - ALUOut ← ALUResult, every cycle.

## Timing
- **Reset.** While reset is high at an edge, PC, IR, Data, A, WriteData, ALUOut and r0–r14 all clear to 0, and every control input is ignored.
  - Outputs after reset: Adr = 0, Instr = 0, WriteData = 0. ALUFlags follows the combinational inputs.
  - Reset asserted mid-instruction aborts that instruction; no partial register write occurs.
- **Combinational outputs.** Adr and ALUFlags are combinational from registers and controls in the same cycle. Instr and WriteData are registered outputs.
- **Latency.**
  - A fetched word appears on Instr one edge after IRWrite.
  - RD1/RD2 appear in A/WriteData one edge after the address selects.
  - An ALU result appears in ALUOut one edge later.
- **r15 = PC+8.** In the decode cycle the controller drives ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10. With PC already advanced by fetch, Result = PC+4, which is the fetch PC + 8.
- **Write/read same register in one cycle.** The read returns the old value; the new value is visible after the edge.
- **PCWrite with RegWrite in one cycle.** Both capture the same Result. r15 as a write destination is ignored; only PCWrite updates the PC.
- **Arithmetic.** Arithmetic wraps modulo 2^32. The PC wraps from 0xFFFFFFFC to 0.

## Structure
- **Shared package (`arm_pkg`):**
  - Enums for ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, with the encodings given above.
  - Flag bit indices: N = 3, Z = 2, C = 1, V = 0.
  - The controller imports the same package.
- **Sub-module `regfile`:** two combinational read ports, one synchronous write port, r15 input, synchronous reset.
- **Inline logic:** ALU, extender and muxes stay inline in `datapath`.

## Test plan
- **Reset.** Hold reset for 2 cycles with random controls → PC = 0, Adr = 0, Instr = 0, WriteData = 0.
- **Fetch.**
  - Stimulus: ReadData = E5902060, IRWrite = 1, PCWrite = 1, AdrSrc = 0, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10, ALUControl = 00.
  - After 1 edge: Instr = E5902060, PC = 4, Adr = 4.
  - Decode cycle: A captures 8 (r15 = PC+8).
- **LDR.**
  - Setup: r0 = 0x100, IR = E5902060, ImmSrc = 01, ALUSrcB = 01.
  - ALUOut = 0x160; with AdrSrc = 1, Adr = 0x160.
  - ReadData = DEADBEEF, then writeback with ResultSrc = 01, RegWrite = 1 → r2 = DEADBEEF.
- **STR.** IR = E5802064, r2 = 0x1234 → WriteData = 0x1234 and Adr = r0 + 0x64 in the memory cycle.
- **Flags.**
  - SUB 5 − 5 → ALUFlags = 0110.
  - ADD 0x7FFFFFFF + 1 → ALUFlags = 1001.
  - AND 0xF0 & 0x0F → ALUFlags = 0100.
- **Branch extend.**
  - Instr[23:0] = 0x00000C, ImmSrc = 10 → ExtImm = 0x30.
  - Instr[23:0] = 0xFFFFFE → ExtImm = 0xFFFFFFF8.
  - Branch target = PC+8 + ExtImm, written to PC when PCWrite = 1.
